ndp_feed_ctrl: RTL and testbench
================================

# ndp_feed_ctrl

Parametrised, multi-bank feed sequencer between the host-written scratch pad and the NDP unit. Tracks per-bank fill level and commit state, and streams committed layers into the NDP unit in strict round-robin bank order. Host refill of free banks overlaps with feeding. Signals end-of-input to the NDP unit and reports completion.

## Interface
- NUM_BANKS, 2, scratch-pad banks; ≥2.
- NUM_LAYERS, 5, max layers per bank.
- LAYER_W, $clog2(NUM_LAYERS), layer index width.
- BANK_W, $clog2(NUM_BANKS), bank index width.
- CNT_W, 16, width of the layers_fed counter.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_in  in  1  level; rising edge starts a job.
- finish_in  in  1  level; rising edge means the host has no more data.
- wr_en  in  1  host layer write strobe.
- wr_bank  in  BANK_W  target bank of the write.
- wr_layer  in  LAYER_W  target layer of the write.
- commit_in  in  1  pulse; marks commit_bank ready.
- commit_bank  in  BANK_W  bank to commit.
- bank_free  out  NUM_BANKS  bit b=1: bank b is writable.
- rd_en  out  1  scratch-pad read strobe; data arrives 1 cycle later.
- rd_bank  out  BANK_W  bank being read.
- rd_layer  out  LAYER_W  layer being read.
- unit_valid  out  1  NDP unit accumulates this cycle (rd_en delayed 1).
- unit_in_done  out  1  all input delivered to the NDP unit.
- unit_calc_done  in  1  NDP unit finished.
- calc_done  out  1  sticky job-complete flag.
- busy  out  1  state is not IDLE and not DONE.
- err  out  1  sticky protocol-violation flag.
- layers_fed  out  CNT_W  layers fed this job; saturating.

## Operation
- Edge detectors on start_in and finish_in. Their history registers reset to 0, so an input held high through reset produces an edge in the first cycle after reset.
- Per-bank state:
  - fill[b] (LAYER_W+1 bits): max written layer + 1.
  - ready[b]: bank committed.
- bank_free[b] = ~ready[b] & ~(state==FEED & cur_bank==b).
- Write (wr_en) to a non-free bank, or with wr_layer ≥ NUM_LAYERS: dropped, err set.
- Commit handling:
  - Commit of a non-free bank: ignored, err set.
  - Commit of a bank with fill==0: ignored, no error.
- FSM, one-hot or encoded, states IDLE, WAIT, FEED, FLUSH, DRAIN, DONE.
  - IDLE: start edge -> WAIT. On entry to WAIT: clear calc_done, layers_fed, finish_seen; set cur_bank=0.
  - WAIT:
    - ready[cur_bank] -> FEED with rd_layer=0.
    - else if finish_seen -> FLUSH.
    - else stay.
  - FEED: rd_en=1 every cycle and rd_layer increments. Meanwhile layers_fed increments per unit_valid. On rd_layer==fill-1:
    - Release the bank: ready=0, fill=0.
    - cur_bank = cur_bank+1 mod NUM_BANKS.
    - If the next bank is already ready, continue FEED at layer 0 with no bubble; else -> WAIT.
  - FLUSH: one cycle for the last unit_valid to retire; -> DRAIN.
  - DRAIN: unit_in_done=1. On unit_calc_done -> DONE.
  - DONE: calc_done=1 and unit_in_done=0. Start edge -> WAIT (new job).
- A finish edge in any state sets finish_seen. It is acted on only in WAIT, so every committed bank is drained first.
- Ignored events:
  - A start edge outside IDLE/DONE.
  - unit_calc_done outside DRAIN.

## Timing
- Reset values:
  - rd_en/unit_valid/unit_in_done/calc_done/busy/err = 0.
  - rd_bank/rd_layer/layers_fed = 0.
  - bank_free = all 1s.
  - State IDLE; ready/fill/finish_seen all cleared.
- Start edge sampled at cycle t -> WAIT at t+1. First rd_en at t+2 if bank 0 is ready.
- unit_valid = rd_en registered (latency 1). rd_bank/rd_layer are registered outputs.
- A commit at cycle t is visible to WAIT at t+1.
- A commit and a release on the same cycle are judged against pre-release state, so a commit of the bank being released is rejected.
- Bank switch inside FEED is gap-free: rd_en stays high across banks.
- calc_done rises the cycle after unit_calc_done is sampled in DRAIN.
- reset_n low mid-job aborts immediately to reset values; no partial flush.

## Structure
- Shared package ndp_pkg holds:
  - typedef ndp_feed_state_t (IDLE, WAIT, FEED, FLUSH, DRAIN, DONE).
  - Width-helper constants shared with the scratch pad (BANK_W, LAYER_W derivation).
- One sub-module, ndp_edge_detect: rising-edge pulse, async active-low reset; instantiated for start_in and finish_in.

## Test plan
- Single bank, 3 layers:
  - Stimulus: write bank0 layers 0–2, commit, start, finish.
  - rd_layer sequence 0,1,2 on consecutive cycles; unit_valid 3 cycles, lagging by 1.
  - unit_in_done after FLUSH; unit_calc_done pulse -> calc_done=1; layers_fed=3.
- Ping-pong, no bubble:
  - Stimulus: banks 0 and 1 committed with 2 and 5 layers.
  - rd_en high 7 consecutive cycles; rd_bank 0,0,1,1,1,1,1; bank_free[0] returns to 1 right after bank 0's last read.
- Overlapped refill:
  - Stimulus: while bank1 feeds, host writes and commits bank0 (4 layers).
  - Feed continues into bank0 after bank1, then WAIT; finish edge -> DRAIN.
- Protocol errors:
  - A write to the bank in FEED sets err=1 and leaves fill unchanged.
  - A zero-fill commit leaves err=0 and ready=0.
- Edge cases:
  - Finish edge during FEED of bank0 while bank1 is ready: both banks drain before unit_in_done.
  - Start edge in DRAIN: ignored.
- Reset mid-FEED:
  - reset_n low at layer 2: all outputs return to reset values in the same cycle.
  - Bank state is cleared; the next start edge waits in WAIT.

Source files
------------

// File: rtl/ndp_pkg.sv
// ndp_pkg: definitions shared by the NDP feed sequencer and the scratch pad.
//   ndp_feed_state_t : feed sequencer FSM states.
//   NDP_NUM_BANKS    : default scratch-pad bank count.
//   NDP_NUM_LAYERS   : default layers per bank.
//   ndp_idx_w()      : index width for an n-entry table (never below 1 bit).
package ndp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } ndp_feed_state_t;

    localparam int NDP_NUM_BANKS  = 2;
    localparam int NDP_NUM_LAYERS = 5;

    function automatic int ndp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ndp_edge_detect.sv
// ndp_edge_detect: one-cycle pulse on a rising edge of a level input.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset; history clears to 0, so a level
//             held high through reset yields a pulse in the first cycle after
//   sig     : level input
//   pulse   : sig & ~sig(previous cycle)
module ndp_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic pulse
);

    logic sig_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_p1 <= 1'b0;
        end else begin
            sig_p1 <= sig;
        end
    end

    assign pulse = sig & ~sig_p1;

endmodule

// File: rtl/ndp_feed_ctrl.sv
// ndp_feed_ctrl: multi-bank feed sequencer between the host-written scratch
// pad and the NDP unit. Tracks fill level and commit state per bank, streams
// committed banks in round-robin order and lets the host refill free banks
// while another bank is being fed.
//   clk, reset_n             : clock / asynchronous active-low reset
//   start_in, finish_in      : levels; rising edges start a job / end input
//   wr_en, wr_bank, wr_layer : host layer write
//   commit_in, commit_bank   : host marks a bank ready
//   bank_free                : per-bank writable flags
//   rd_en, rd_bank, rd_layer : scratch-pad read request (data 1 cycle later)
//   unit_valid               : NDP unit accumulates (rd_en delayed 1)
//   unit_in_done             : all input delivered
//   unit_calc_done           : NDP unit finished
//   calc_done, busy, err     : job complete / active / sticky protocol error
//   layers_fed               : saturating count of layers fed this job
module ndp_feed_ctrl
    import ndp_pkg::*;
#(
    parameter int NUM_BANKS  = NDP_NUM_BANKS,
    parameter int NUM_LAYERS = NDP_NUM_LAYERS,
    parameter int LAYER_W    = ndp_idx_w(NUM_LAYERS),
    parameter int BANK_W     = ndp_idx_w(NUM_BANKS),
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_in,
    input  logic                 finish_in,
    input  logic                 wr_en,
    input  logic [BANK_W-1:0]    wr_bank,
    input  logic [LAYER_W-1:0]   wr_layer,
    input  logic                 commit_in,
    input  logic [BANK_W-1:0]    commit_bank,
    output logic [NUM_BANKS-1:0] bank_free,
    output logic                 rd_en,
    output logic [BANK_W-1:0]    rd_bank,
    output logic [LAYER_W-1:0]   rd_layer,
    output logic                 unit_valid,
    output logic                 unit_in_done,
    input  logic                 unit_calc_done,
    output logic                 calc_done,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     layers_fed
);

    localparam logic [BANK_W:0]  BANK_LIM  = (BANK_W+1)'(NUM_BANKS);
    localparam logic [LAYER_W:0] LAYER_LIM = (LAYER_W+1)'(NUM_LAYERS);

    function automatic logic bank_ok(input logic [BANK_W-1:0] b);
        return {1'b0, b} < BANK_LIM;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    ndp_feed_state_t        state_q, state_d;
    logic [LAYER_W:0]       fill_q [NUM_BANKS];
    logic [NUM_BANKS-1:0]   ready_q;
    logic [BANK_W-1:0]      cur_bank_q, next_bank;
    logic [LAYER_W-1:0]     rd_layer_q;
    logic                   finish_seen_q, calc_done_q, err_q, vld_p1;
    logic [CNT_W-1:0]       layers_fed_q;
    logic                   start_edge, finish_edge;
    logic                   feeding, last_layer, bank_done, enter_wait;
    logic                   wr_ok, commit_free, commit_ok;
    logic [LAYER_W:0]       wr_fill;

    ndp_edge_detect u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (start_in),
        .pulse   (start_edge)
    );

    ndp_edge_detect u_finish_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (finish_in),
        .pulse   (finish_edge)
    );

    assign feeding    = (state_q == FEED);
    assign next_bank  = (cur_bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : cur_bank_q + BANK_W'(1);
    assign last_layer = ({1'b0, rd_layer_q} == fill_q[cur_bank_q] - (LAYER_W+1)'(1));
    assign bank_done  = feeding & last_layer;

    always_comb begin
        bank_free = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_free[b] = ~ready_q[b] & ~(feeding & (cur_bank_q == BANK_W'(b)));
        end
    end

    // Host accesses are judged against pre-release state: the bank being
    // released this cycle still reads as not free.
    assign wr_fill     = {1'b0, wr_layer} + (LAYER_W+1)'(1);
    assign wr_ok       = wr_en & bank_ok(wr_bank) & bank_free[wr_bank] & (wr_fill <= LAYER_LIM);
    assign commit_free = commit_in & bank_ok(commit_bank) & bank_free[commit_bank];
    assign commit_ok   = commit_free & (fill_q[commit_bank] != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_wait = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d    = WAIT;
                    enter_wait = 1'b1;
                end
            end
            WAIT: begin
                if (ready_q[cur_bank_q]) begin
                    state_d = FEED;
                end else if (finish_seen_q) begin
                    state_d = FLUSH;
                end
            end
            FEED: begin
                // Gap-free switch only when the next bank was already committed.
                if (last_layer && !ready_q[next_bank]) begin
                    state_d = WAIT;
                end
            end
            FLUSH:   state_d = DRAIN;
            DRAIN: begin
                if (unit_calc_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: read request issued, NDP unit consumes data next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                fill_q[b] <= '0;
            end
            ready_q       <= '0;
            cur_bank_q    <= '0;
            rd_layer_q    <= '0;
            finish_seen_q <= 1'b0;
            calc_done_q   <= 1'b0;
            err_q         <= 1'b0;
            vld_p1        <= 1'b0;
            layers_fed_q  <= '0;
        end else begin
            vld_p1 <= feeding;

            if ((wr_en && !wr_ok) || (commit_in && !commit_free)) begin
                err_q <= 1'b1;
            end
            if (wr_ok && (wr_fill > fill_q[wr_bank])) begin
                fill_q[wr_bank] <= wr_fill;
            end
            if (commit_ok) begin
                ready_q[commit_bank] <= 1'b1;
            end

            if (bank_done) begin
                ready_q[cur_bank_q] <= 1'b0;
                fill_q[cur_bank_q]  <= '0;
                cur_bank_q          <= next_bank;
                rd_layer_q          <= '0;
            end else if (feeding) begin
                rd_layer_q <= rd_layer_q + LAYER_W'(1);
            end

            if (enter_wait) begin
                cur_bank_q    <= '0;
                calc_done_q   <= 1'b0;
                layers_fed_q  <= '0;
                finish_seen_q <= 1'b0;
            end else if (vld_p1) begin
                layers_fed_q <= sat_inc(layers_fed_q);
            end
            if (finish_edge) begin
                finish_seen_q <= 1'b1;
            end
            if (state_q == DRAIN && unit_calc_done) begin
                calc_done_q <= 1'b1;
            end
        end
    end

    assign rd_en        = feeding;
    assign rd_bank      = cur_bank_q;
    assign rd_layer     = rd_layer_q;
    assign unit_valid   = vld_p1;
    assign unit_in_done = (state_q == DRAIN);
    assign calc_done    = calc_done_q;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign err          = err_q;
    assign layers_fed   = layers_fed_q;

endmodule

// File: tb/tb_ndp_feed_ctrl.sv
module tb_ndp_feed_ctrl;

    localparam int NB = 2;
    localparam int NL = 5;
    localparam int LW = 3;
    localparam int BW = 1;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_in = 1'b0, finish_in = 1'b0;
    logic          wr_en = 1'b0;
    logic [BW-1:0] wr_bank = '0;
    logic [LW-1:0] wr_layer = '0;
    logic          commit_in = 1'b0;
    logic [BW-1:0] commit_bank = '0;
    logic [NB-1:0] bank_free;
    logic          rd_en;
    logic [BW-1:0] rd_bank;
    logic [LW-1:0] rd_layer;
    logic          unit_valid, unit_in_done;
    logic          unit_calc_done = 1'b0;
    logic          calc_done, busy, err;
    logic [CW-1:0] layers_fed;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected read order, coded as bank*16 + layer.
    int exp_rd[$];

    // Behavioural bank model for the randomised jobs.
    int fill_m [NB];
    bit ready_m [NB];
    bit err_m;

    ndp_feed_ctrl #(
        .NUM_BANKS (NB), .NUM_LAYERS (NL), .LAYER_W (LW), .BANK_W (BW), .CNT_W (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_in       (start_in),
        .finish_in      (finish_in),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_layer       (wr_layer),
        .commit_in      (commit_in),
        .commit_bank    (commit_bank),
        .bank_free      (bank_free),
        .rd_en          (rd_en),
        .rd_bank        (rd_bank),
        .rd_layer       (rd_layer),
        .unit_valid     (unit_valid),
        .unit_in_done   (unit_in_done),
        .unit_calc_done (unit_calc_done),
        .calc_done      (calc_done),
        .busy           (busy),
        .err            (err),
        .layers_fed     (layers_fed)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int b, input int l);
        wr_bank = BW'(b); wr_layer = LW'(l); wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic host_commit(input int b);
        commit_bank = BW'(b); commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1; tick(); start_in = 1'b0;
    endtask

    task automatic pulse_finish();
        finish_in = 1'b1; tick(); finish_in = 1'b0;
    endtask

    function automatic void push_bank(input int b, input int n);
        for (int l = 0; l < n; l++) exp_rd.push_back(b * 16 + l);
    endfunction

    function automatic int exp_free();
        int v = 0;
        for (int b = 0; b < NB; b++) if (!ready_m[b]) v |= (1 << b);
        return v;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin fill_m[b] = 0; ready_m[b] = 1'b0; end
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start_in = 1'b0; finish_in = 1'b0; wr_en = 1'b0; commit_in = 1'b0;
        unit_calc_done = 1'b0;
        exp_rd.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rd_en"},      32'(rd_en), 0);
        check_val({tag, "_unit_valid"}, 32'(unit_valid), 0);
        check_val({tag, "_in_done"},    32'(unit_in_done), 0);
        check_val({tag, "_calc_done"},  32'(calc_done), 0);
        check_val({tag, "_busy"},       32'(busy), 0);
        check_val({tag, "_err"},        32'(err), 0);
        check_val({tag, "_rd_bank"},    32'(rd_bank), 0);
        check_val({tag, "_rd_layer"},   32'(rd_layer), 0);
        check_val({tag, "_layers_fed"}, 32'(layers_fed), 0);
        check_val({tag, "_bank_free"},  32'(bank_free), 32'h3);
    endtask

    task automatic wait_in_done(input string tag);
        for (int i = 0; i < 200 && !unit_in_done; i++) tick();
        check_val({tag, "_in_done"}, 32'(unit_in_done), 1);
    endtask

    task automatic end_job(input string tag, input int exp_fed);
        wait_in_done(tag);
        check_val({tag, "_fed"}, 32'(layers_fed), exp_fed);
        check_val({tag, "_drained"}, exp_rd.size(), 0);
        unit_calc_done = 1'b1; tick(); unit_calc_done = 1'b0;
        check_val({tag, "_calc_done"}, 32'(calc_done), 1);
        check_val({tag, "_busy_done"}, 32'(busy), 0);
        check_val({tag, "_in_done_clr"}, 32'(unit_in_done), 0);
    endtask

    // Read-order scoreboard and one-cycle unit_valid lag.
    bit prev_rd = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_rd = 1'b0;
        end else begin
            check_val("unit_valid_lag", 32'(unit_valid), 32'(prev_rd));
            if (rd_en) begin
                if (exp_rd.size() == 0) begin
                    check_val("rd_unexpected", int'(rd_bank) * 16 + int'(rd_layer), 32'hFFFF);
                end else begin
                    check_val("rd_seq", int'(rd_bank) * 16 + int'(rd_layer), exp_rd.pop_front());
                end
            end
            prev_rd = rd_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, l, nops, fed, found;
        int bank_seq[7] = '{0, 0, 1, 1, 1, 1, 1};

        // Single bank, three layers, exact cycle timing.
        do_reset();
        check_reset_vals("rst");
        host_write(0, 0); host_write(0, 1); host_write(0, 2);
        check_val("t1_free_written", 32'(bank_free), 32'h3);
        host_commit(0);
        check_val("t1_free_commit", 32'(bank_free), 32'h2);
        push_bank(0, 3);
        pulse_start();
        check_val("t1_wait_busy", 32'(busy), 1);
        check_val("t1_wait_rd", 32'(rd_en), 0);
        tick();
        check_val("t1_rd0", 32'(rd_en), 1);
        check_val("t1_layer0", 32'(rd_layer), 0);
        check_val("t1_free_feed", 32'(bank_free), 32'h2);
        tick();
        check_val("t1_layer1", 32'(rd_layer), 1);
        tick();
        check_val("t1_layer2", 32'(rd_layer), 2);
        tick();
        check_val("t1_rd_off", 32'(rd_en), 0);
        check_val("t1_free_rel", 32'(bank_free), 32'h3);
        pulse_finish();
        tick();
        check_val("t1_flush", 32'(unit_in_done), 0);
        tick();
        check_val("t1_drain", 32'(unit_in_done), 1);
        end_job("t1", 3);
        tick();
        check_val("t1_sticky", 32'(calc_done), 1);

        // Ping-pong 2 + 5 layers with no bubble; out-of-range layer write.
        do_reset();
        host_write(1, 6);
        check_val("t2_err_layer", 32'(err), 1);
        host_write(0, 1); host_write(1, 4); host_write(1, 0);
        host_commit(0); host_commit(1);
        check_val("t2_free_both", 32'(bank_free), 0);
        push_bank(0, 2); push_bank(1, 5);
        pulse_start();
        tick();
        for (int k = 0; k < 7; k++) begin
            check_val("t2_rd_en", 32'(rd_en), 1);
            check_val("t2_rd_bank", 32'(rd_bank), bank_seq[k]);
            check_val("t2_free", 32'(bank_free), (k < 2) ? 0 : 1);
            tick();
        end
        check_val("t2_rd_off", 32'(rd_en), 0);
        pulse_finish();
        end_job("t2", 7);

        // Overlapped refill of bank 0 while bank 1 feeds.
        do_reset();
        host_write(0, 0); host_write(1, 2);
        host_commit(0); host_commit(1);
        push_bank(0, 1); push_bank(1, 3); push_bank(0, 4);
        pulse_start();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en && rd_bank == 1) begin found = 1; break; end
            tick();
        end
        check_val("t3_b1_feeding", found, 1);
        host_write(0, 3);
        host_commit(0);
        for (int i = 0; i < 30 && rd_en; i++) tick();
        check_val("t3_wait_rd", 32'(rd_en), 0);
        tick();
        check_val("t3_still_wait", 32'(rd_en), 0);
        check_val("t3_busy", 32'(busy), 1);
        check_val("t3_err", 32'(err), 0);
        pulse_finish();
        end_job("t3", 8);

        // Zero-fill commit and write to the bank being fed.
        do_reset();
        host_commit(1);
        check_val("t4_zero_commit_err", 32'(err), 0);
        check_val("t4_zero_commit_free", 32'(bank_free), 32'h3);
        host_write(0, 2); host_commit(0);
        push_bank(0, 3);
        pulse_start();
        tick();
        check_val("t4_feeding", 32'(rd_en), 1);
        host_write(0, 4);
        check_val("t4_err_feed_wr", 32'(err), 1);
        pulse_finish();
        end_job("t4", 3);

        // Finish during feed with the next bank ready; start/calc_done ignored.
        do_reset();
        host_write(0, 2); host_write(1, 1);
        host_commit(0); host_commit(1);
        push_bank(0, 3); push_bank(1, 2);
        pulse_start();
        tick();
        unit_calc_done = 1'b1; finish_in = 1'b1;
        tick();
        unit_calc_done = 1'b0; finish_in = 1'b0;
        check_val("t5_calc_ignored", 32'(calc_done), 0);
        wait_in_done("t5");
        check_val("t5_fed", 32'(layers_fed), 5);
        check_val("t5_drained", exp_rd.size(), 0);
        pulse_start();
        check_val("t5_start_ign_done", 32'(unit_in_done), 1);
        check_val("t5_start_ign_busy", 32'(busy), 1);
        unit_calc_done = 1'b1; tick(); unit_calc_done = 1'b0;
        check_val("t5_calc_done", 32'(calc_done), 1);
        pulse_start();
        check_val("t5_restart_busy", 32'(busy), 1);
        check_val("t5_restart_calc", 32'(calc_done), 0);
        check_val("t5_restart_fed", 32'(layers_fed), 0);
        pulse_finish();
        end_job("t5b", 0);

        // Reset in the middle of a feed, start held high through reset.
        do_reset();
        host_write(0, 4); host_write(1, 0);
        host_commit(0); host_commit(1);
        push_bank(0, 5);
        pulse_start();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en && rd_layer == 2) begin found = 1; break; end
            tick();
        end
        check_val("t6_at_layer2", found, 1);
        reset_n = 1'b0; start_in = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        exp_rd.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check_val("t6_wait_busy", 32'(busy), 1);
        check_val("t6_free_cleared", 32'(bank_free), 32'h3);
        start_in = 1'b0;
        repeat (3) begin
            tick();
            check_val("t6_no_feed", 32'(rd_en), 0);
        end
        pulse_finish();
        end_job("t6", 0);

        // Randomised jobs against the bank model.
        do_reset();
        model_clear();
        for (int j = 0; j < 40; j++) begin
            if (j % 8 == 7) begin do_reset(); model_clear(); end
            nops = $urandom_range(2, 8);
            for (int o = 0; o < nops; o++) begin
                b = $urandom_range(0, NB - 1);
                if ($urandom_range(0, 2) != 0) begin
                    l = $urandom_range(0, 7);
                    if (ready_m[b] || l >= NL) err_m = 1'b1;
                    else if (l + 1 > fill_m[b]) fill_m[b] = l + 1;
                    host_write(b, l);
                end else begin
                    if (ready_m[b]) err_m = 1'b1;
                    else if (fill_m[b] != 0) ready_m[b] = 1'b1;
                    host_commit(b);
                end
            end
            check_val("rnd_err", 32'(err), 32'(err_m));
            check_val("rnd_free", 32'(bank_free), exp_free());
            fed = 0;
            b = 0;
            while (ready_m[b]) begin
                push_bank(b, fill_m[b]);
                fed += fill_m[b];
                ready_m[b] = 1'b0;
                fill_m[b] = 0;
                b = (b + 1) % NB;
            end
            pulse_start();
            repeat ($urandom_range(0, 12)) tick();
            pulse_finish();
            end_job("rnd", fed);
            check_val("rnd_free_end", 32'(bank_free), exp_free());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
